// File: rtl/trc_pkg.sv
// Shared definitions for the twisted ring counter: mode codes, the per-edge
// action selector, and helpers that map a phase index to its state encoding.
package trc_pkg;

    localparam int MODE_JOHNSON = 0;
    localparam int MODE_RING    = 1;
    localparam int MAX_WIDTH    = 16;

    // What the counter does on the next clock edge, in priority order.
    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_STEP,
        ACT_RECOVER,
        ACT_LOAD,
        ACT_BAD_LOAD,
        ACT_CLEAR
    } action_t;

    // Number of distinct phases in one full cycle of the sequence.
    function automatic int num_states(input int width, input int mode);
        return (mode == MODE_RING) ? width : 2 * width;
    endfunction

    // State encoding of phase k. Johnson: the low k bits set for k <= width,
    // otherwise bits k-width..width-1 set. Ring: a single one at bit k.
    function automatic logic [MAX_WIDTH-1:0] phase_to_q(input int k, input int width,
                                                        input int mode);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (mode == MODE_RING)
                v[i] = (i == k);
            else if (k <= width)
                v[i] = (i < k);
            else
                v[i] = (i >= k - width) && (i < width);
        end
        return v;
    endfunction

endpackage

// File: rtl/trc_decode.sv
// Combinational decode of the counter state into a binary phase index and a
// legality flag. An unrecognised state reports phase 0 with legal low.
module trc_decode
    import trc_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int MODE  = MODE_JOHNSON,
    parameter int PW    = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] q,
    output logic [PW-1:0]    phase,
    output logic             legal
);

    localparam int S = num_states(WIDTH, MODE);

    // Match q against every legal encoding; at most one can hit.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path infers a latch.
        phase = '0;
        legal = 1'b0;
        for (int k = 0; k < S; k++) begin
            if (q == WIDTH'(phase_to_q(k, WIDTH, MODE))) begin
                phase = PW'(k);
                legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/twisted_ring_counter.sv
// Johnson / one-hot ring counter with direction control, synchronous clear
// and phase load, illegal-state recovery and a registered error pulse.
module twisted_ring_counter
    import trc_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int MODE  = MODE_JOHNSON,
    localparam int PW   = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             dir,
    input  logic             clr,
    input  logic             ld,
    input  logic [PW-1:0]    ld_phase,
    output logic [WIDTH-1:0] q,
    output logic [PW-1:0]    phase,
    output logic             tc,
    output logic             err
);

    localparam int               S      = num_states(WIDTH, MODE);
    localparam logic [WIDTH-1:0] Q_ZERO = WIDTH'(phase_to_q(0, WIDTH, MODE));

    logic [WIDTH-1:0] q_state;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] q_fwd;
    logic [WIDTH-1:0] q_rev;
    logic [WIDTH-1:0] q_load;
    logic             err_next;
    logic             legal;
    action_t          action;

    trc_decode #(
        .WIDTH (WIDTH),
        .MODE  (MODE),
        .PW    (PW)
    ) u_decode (
        .q     (q_state),
        .phase (phase),
        .legal (legal)
    );

    // Pick this edge's action: clear > load > recovery > step > hold.
    always_comb begin
        action = ACT_HOLD;
        if (clr)
            action = ACT_CLEAR;
        else if (ld)
            action = (32'(ld_phase) < 32'(S)) ? ACT_LOAD : ACT_BAD_LOAD;
        else if (!legal)
            action = ACT_RECOVER;
        else if (en)
            action = ACT_STEP;
    end

    // One-step neighbours of the current state in each direction.
    always_comb begin
        if (MODE == MODE_RING) begin
            q_fwd = {q_state[WIDTH-2:0], q_state[WIDTH-1]};
            q_rev = {q_state[0], q_state[WIDTH-1:1]};
        end else begin
            q_fwd = {q_state[WIDTH-2:0], ~q_state[WIDTH-1]};
            q_rev = {~q_state[0], q_state[WIDTH-1:1]};
        end
    end

    // Encoding of the requested load phase (only used when it is in range).
    always_comb begin
        q_load = Q_ZERO;
        for (int k = 0; k < S; k++) begin
            if (ld_phase == PW'(k))
                q_load = WIDTH'(phase_to_q(k, WIDTH, MODE));
        end
    end

    // Next state and next error flag from the selected action.
    always_comb begin
        q_next   = q_state;
        err_next = 1'b0;
        case (action)
            ACT_CLEAR:    q_next = Q_ZERO;
            ACT_LOAD:     q_next = q_load;
            ACT_BAD_LOAD: err_next = 1'b1;
            ACT_RECOVER: begin
                q_next   = Q_ZERO;
                err_next = 1'b1;
            end
            ACT_STEP:     q_next = dir ? q_rev : q_fwd;
            default:      q_next = q_state;
        endcase
    end

    // State and error registers; reset lands on phase 0 with no error.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rstn) begin
            q_state <= Q_ZERO;
            err     <= 1'b0;
        end else begin
            q_state <= q_next;
            err     <= err_next;
        end
    end

    assign q  = q_state;
    assign tc = en & ~clr & ~ld & legal & (dir ? (phase == '0) : (phase == PW'(S - 1)));

endmodule

// File: tb/tb_twisted_ring_counter.sv
// Self-checking bench: a Johnson WIDTH=3 counter and a ring WIDTH=4 counter
// share one directed stimulus stream and are compared every cycle against a
// phase-index model, plus literal expectations pinned to individual vectors.
module tb_twisted_ring_counter;

    localparam int SA = 6;   // Johnson, WIDTH=3
    localparam int SB = 4;   // ring, WIDTH=4

    typedef enum int {
        LIT_NONE, LIT_A_Q, LIT_A_TC, LIT_A_ERR, LIT_A_PHASE, LIT_B_Q, LIT_B_TC, LIT_B_ERR
    } lit_e;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en, dir, clr, ld;
    logic [2:0] ld_phase;

    logic [2:0] q_a, phase_a;
    logic       tc_a, err_a;
    logic [3:0] q_b;
    logic [2:0] phase_b;
    logic       tc_b, err_b;

    // Model state: phase index and pending error per counter.
    int   p_a = 0;
    int   p_b = 0;
    logic e_a = 1'b0;
    logic e_b = 1'b0;
    logic ill_a;            // counter A currently holds a forced illegal value

    lit_e        lit_kind;
    logic [31:0] lit_val;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    twisted_ring_counter #(.WIDTH(3), .MODE(0)) dut_a (
        .clk(clk), .rstn(rstn), .en(en), .dir(dir), .clr(clr), .ld(ld),
        .ld_phase(ld_phase), .q(q_a), .phase(phase_a), .tc(tc_a), .err(err_a)
    );

    twisted_ring_counter #(.WIDTH(4), .MODE(1)) dut_b (
        .clk(clk), .rstn(rstn), .en(en), .dir(dir), .clr(clr), .ld(ld),
        .ld_phase(ld_phase), .q(q_b), .phase(phase_b), .tc(tc_b), .err(err_b)
    );

    // Encoding of phase k written directly from the sequence rules.
    function automatic logic [31:0] enc(input int w, input int m, input int k);
        if (m == 1) return 32'(1) << k;
        if (k <= w) return (32'(1) << k) - 32'(1);
        return ((32'(1) << w) - 32'(1)) ^ ((32'(1) << (k - w)) - 32'(1));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances phase indices by the counter rules each edge.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_a <= 0; p_b <= 0; e_a <= 1'b0; e_b <= 1'b0;
        end else begin
            if (clr) begin
                p_a <= 0; e_a <= 1'b0;
            end else if (ld) begin
                if (int'(ld_phase) < SA) begin p_a <= int'(ld_phase); e_a <= 1'b0; end
                else e_a <= 1'b1;
            end else if (ill_a) begin
                p_a <= 0; e_a <= 1'b1;
            end else begin
                e_a <= 1'b0;
                if (en) p_a <= dir ? (p_a + SA - 1) % SA : (p_a + 1) % SA;
            end

            if (clr) begin
                p_b <= 0; e_b <= 1'b0;
            end else if (ld) begin
                if (int'(ld_phase) < SB) begin p_b <= int'(ld_phase); e_b <= 1'b0; end
                else e_b <= 1'b1;
            end else begin
                e_b <= 1'b0;
                if (en) p_b <= dir ? (p_b + SB - 1) % SB : (p_b + 1) % SB;
            end
        end
    end

    // Compare both counters against the model away from the active edge.
    always @(negedge clk) begin
        check("a_q",     32'(q_a),     ill_a ? 32'h2 : enc(3, 0, p_a));
        check("a_phase", 32'(phase_a), ill_a ? 32'd0 : 32'(p_a));
        check("a_tc",    32'(tc_a),    32'(en & ~clr & ~ld & ~ill_a &
                                           (dir ? (p_a == 0) : (p_a == SA - 1))));
        check("a_err",   32'(err_a),   32'(e_a));
        check("b_q",     32'(q_b),     enc(4, 1, p_b));
        check("b_phase", 32'(phase_b), 32'(p_b));
        check("b_tc",    32'(tc_b),    32'(en & ~clr & ~ld &
                                           (dir ? (p_b == 0) : (p_b == SB - 1))));
        check("b_err",   32'(err_b),   32'(e_b));
        case (lit_kind)
            LIT_A_Q:     check("lit_a_q",     32'(q_a),     lit_val);
            LIT_A_TC:    check("lit_a_tc",    32'(tc_a),    lit_val);
            LIT_A_ERR:   check("lit_a_err",   32'(err_a),   lit_val);
            LIT_A_PHASE: check("lit_a_phase", 32'(phase_a), lit_val);
            LIT_B_Q:     check("lit_b_q",     32'(q_b),     lit_val);
            LIT_B_TC:    check("lit_b_tc",    32'(tc_b),    lit_val);
            LIT_B_ERR:   check("lit_b_err",   32'(err_b),   lit_val);
            default: ;
        endcase
    end

    // Apply one vector just after an edge; the literal names what must be
    // visible before the next edge.
    task automatic drive(input logic e, input logic d, input logic c, input logic l,
                         input logic [2:0] lp, input lit_e k, input logic [31:0] v);
        en = e; dir = d; clr = c; ld = l; ld_phase = lp;
        lit_kind = k; lit_val = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b1; en = 1'b0; dir = 1'b0; clr = 1'b0; ld = 1'b0; ld_phase = 3'd0;
        ill_a = 1'b0; lit_kind = LIT_NONE; lit_val = '0;
        #1 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Forward Johnson sequence with wrap; tc while at 100.
        drive(1, 0, 0, 0, 3'd0, LIT_A_Q,  32'b000);
        drive(1, 0, 0, 0, 3'd0, LIT_A_Q,  32'b001);
        drive(1, 0, 0, 0, 3'd0, LIT_A_Q,  32'b011);
        drive(1, 0, 0, 0, 3'd0, LIT_A_Q,  32'b111);
        drive(1, 0, 0, 0, 3'd0, LIT_A_Q,  32'b110);
        drive(1, 0, 0, 0, 3'd0, LIT_A_TC, 32'd1);
        drive(1, 0, 0, 0, 3'd0, LIT_A_Q,  32'b000);

        // Clear, then reverse from phase 0; immediate direction changes.
        drive(1, 0, 1, 0, 3'd0, LIT_A_Q,  32'b001);
        drive(1, 1, 0, 0, 3'd0, LIT_A_TC, 32'd1);
        drive(1, 1, 0, 0, 3'd0, LIT_A_Q,  32'b100);
        drive(1, 1, 0, 0, 3'd0, LIT_A_Q,  32'b110);
        drive(0, 1, 0, 0, 3'd0, LIT_A_Q,  32'b111);
        drive(1, 0, 0, 0, 3'd0, LIT_A_Q,  32'b111);
        drive(1, 1, 0, 0, 3'd0, LIT_A_Q,  32'b110);

        // Ring load and stepping, out-of-range loads and their error pulses.
        drive(0, 0, 0, 1, 3'd2, LIT_B_Q,   32'b0010);
        drive(1, 0, 0, 0, 3'd0, LIT_B_Q,   32'b0100);
        drive(1, 0, 0, 0, 3'd0, LIT_B_TC,  32'd1);
        drive(0, 0, 0, 0, 3'd0, LIT_B_Q,   32'b0001);
        drive(0, 0, 0, 1, 3'd5, LIT_B_Q,   32'b0001);
        drive(0, 0, 0, 0, 3'd0, LIT_B_ERR, 32'd1);
        drive(0, 0, 0, 0, 3'd0, LIT_B_ERR, 32'd0);
        drive(1, 0, 0, 1, 3'd6, LIT_A_Q,   32'b100);
        drive(0, 0, 0, 0, 3'd0, LIT_A_ERR, 32'd1);
        drive(1, 0, 0, 1, 3'd3, LIT_A_ERR, 32'd0);
        drive(0, 0, 0, 0, 3'd0, LIT_B_Q,   32'b1000);

        // Clear wins over a simultaneous load and suppresses tc.
        drive(1, 0, 1, 1, 3'd3, LIT_B_TC,  32'd0);
        drive(0, 0, 0, 0, 3'd0, LIT_A_Q,   32'b000);
        drive(0, 0, 0, 0, 3'd0, LIT_A_ERR, 32'd0);

        // Illegal state 010 recovers to phase 0 with en low, err one cycle.
        en = 1'b0; dir = 1'b0; clr = 1'b0; ld = 1'b0; ld_phase = 3'd0;
        lit_kind = LIT_A_PHASE; lit_val = 32'd0;
        force dut_a.q_state = 3'b010;
        #1 release dut_a.q_state;
        ill_a = 1'b1;
        @(posedge clk);
        #1 ill_a = 1'b0;
        drive(0, 0, 0, 0, 3'd0, LIT_A_ERR, 32'd1);
        drive(0, 0, 0, 0, 3'd0, LIT_A_ERR, 32'd0);

        // Asynchronous reset mid-count at 111, then resume from phase 0.
        drive(1, 0, 0, 0, 3'd0, LIT_A_Q, 32'b000);
        drive(1, 0, 0, 0, 3'd0, LIT_A_Q, 32'b001);
        drive(1, 0, 0, 0, 3'd0, LIT_A_Q, 32'b011);
        en = 1'b1; lit_kind = LIT_A_Q; lit_val = 32'b000;
        #2 rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        drive(1, 0, 0, 0, 3'd0, LIT_A_Q, 32'b000);
        drive(1, 0, 0, 0, 3'd0, LIT_A_Q, 32'b001);

        // Mixed command stream checked by the model alone.
        for (int i = 0; i < 48; i++) begin
            drive((i % 3) != 0, i[2], (i % 11) == 10, (i % 7) == 3, 3'(i % 8),
                  LIT_NONE, 32'd0);
        end

        lit_kind = LIT_NONE;
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
